// File: rtl/mem_req_pkg.sv
// Shared types and default widths for the data-memory requester.
//   mem_req_state_t : requester FSM states
//   MEM_ADDR_W / MEM_DATA_W / MEM_LEN_W : default memory and burst widths
//   STAT_W : width of the optional beat statistics counters
package mem_req_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } mem_req_state_t;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_LEN_W  = 4;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/mem_req_stats.sv
// Saturating beat counters for the data-memory requester.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   rd_inc_i, wr_inc_i : one-cycle increment strobes
//   rd_cnt_o, wr_cnt_o : counter values, stick at all-ones
module mem_req_stats
  import mem_req_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rd_inc_i,
  input  logic         wr_inc_i,
  output logic [W-1:0] rd_cnt_o,
  output logic [W-1:0] wr_cnt_o
);

  logic [W-1:0] rd_cnt_q, rd_cnt_d;
  logic [W-1:0] wr_cnt_q, wr_cnt_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + W'(1) : v;
  endfunction

  always_comb begin
    rd_cnt_d = sat_inc(rd_cnt_q, rd_inc_i);
    wr_cnt_d = sat_inc(wr_cnt_q, wr_inc_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: rtl/mem_requester.sv
// Initiator front-end for the 256x32 synchronous data memory. Turns a
// valid/ready request stream into memory strobes and returns registered
// read data on a valid/ready response channel. Supports read bursts and
// write fill bursts (one word to consecutive addresses), addresses wrap.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_len : request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_last                   : read response
//   wr_done                                                  : fill finished pulse
//   mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata              : memory side
//   stat_rd_cnt/stat_wr_cnt                                  : beat statistics
// Build option: define MEM_REQUESTER_STATS_EN to generate the statistics
// counters; otherwise the stat ports are tied to zero.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_wr_cnt
);

  mem_req_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_last_q, rsp_last_d;
  logic              wr_done_q, wr_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    wr_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_len;
          state_d = req_write ? WRITE : RD_ISSUE;
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // The memory clears its output on this same edge, so the value seen
        // here is still the read result registered by the issue cycle.
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == '0);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cnt_q == '0) begin
            rsp_last_d = 1'b0;
            state_d    = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset drops mem_en without a clock.
  assign req_ready = (state_q == IDLE);
  assign mem_en    = (state_q == WRITE) || (state_q == RD_ISSUE);
  assign mem_wen   = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;

`ifdef MEM_REQUESTER_STATS_EN
  logic rd_inc, wr_inc;
  assign rd_inc = (state_q == RESP) && rsp_valid_q && rsp_ready;
  assign wr_inc = (state_q == WRITE);

  mem_req_stats #(
    .W(STAT_W)
  ) u_stats (
    .clk_i   (clk),
    .rst_i   (rst),
    .rd_inc_i(rd_inc),
    .wr_inc_i(wr_inc),
    .rd_cnt_o(stat_rd_cnt),
    .wr_cnt_o(stat_wr_cnt)
  );
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester with a behavioural 256x32 memory
// and write/read scoreboards.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_last;
  logic        wr_done;
  logic        mem_en;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;

  int checks = 0;
  int errors = 0;
  logic b2b_mon = 1'b0;

  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_exp_t;
  typedef struct packed {logic [31:0] data; logic last;} rd_exp_t;
  wr_exp_t wq[$];
  rd_exp_t rq[$];
  wr_exp_t mon_we;
  rd_exp_t mon_re;

  logic [31:0] tbmem [256];
  logic [31:0] ref_mem [256];

  mem_requester dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .wr_done(wr_done),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registered read, output cleared while disabled.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) tbmem[mem_addr] <= mem_wdata;
      else         mem_rdata <= tbmem[mem_addr];
    end else begin
      mem_rdata <= '0;
    end
  end

  // Scoreboard consumers: every write strobe and every response handshake.
  always @(negedge clk) begin
    if (!rst && mem_en && mem_wen) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, nothing expected", mem_addr, mem_wdata);
      end else begin
        mon_we = wq.pop_front();
        if ({mem_addr, mem_wdata} !== {mon_we.addr, mon_we.data}) begin
          errors++;
          $display("FAIL write_beat: got addr %h data %h, expected addr %h data %h",
                   mem_addr, mem_wdata, mon_we.addr, mon_we.data);
        end
      end
    end
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: data %h last %b, nothing expected", rsp_rdata, rsp_last);
      end else begin
        mon_re = rq.pop_front();
        if ({rsp_rdata, rsp_last} !== {mon_re.data, mon_re.last}) begin
          errors++;
          $display("FAIL read_beat: got data %h last %b, expected data %h last %b",
                   rsp_rdata, rsp_last, mon_re.data, mon_re.last);
        end
      end
    end
    if (b2b_mon) begin
      checks++;
      if (req_ready && (mem_en || rsp_valid)) begin
        errors++;
        $display("FAIL ready_outside_idle: req_ready %b with mem_en %b rsp_valid %b, expected 0",
                 req_ready, mem_en, rsp_valid);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_req(input bit w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] len);
    bit ok;
    for (int i = 0; i <= int'(len); i++) begin
      logic [7:0] ai;
      ai = a + 8'(i);
      if (w) begin
        ref_mem[ai] = d;
        wq.push_back('{addr: ai, data: d});
      end else begin
        rq.push_back('{data: ref_mem[ai], last: (i == int'(len))});
      end
    end
    req_write = w; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_accept: req_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (req_ready && !rsp_valid && wq.size() == 0 && rq.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: pending writes %0d reads %0d, expected 0", wq.size(), rq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0; rsp_ready = 1'b1; rst = 1'b1;
    wq.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_last, wr_done, mem_en, mem_wen} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/valid/last/done/en/wen %b, expected 100000",
               {req_ready, rsp_valid, rsp_last, wr_done, mem_en, mem_wen});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata %h addr %h wdata %h, expected all 0",
               rsp_rdata, mem_addr, mem_wdata);
    end
    checks++;
    if ({stat_rd_cnt, stat_wr_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_stats: got rd %0d wr %0d, expected 0 0", stat_rd_cnt, stat_wr_cnt);
    end
    do_reset();
  endtask

  task automatic test_single();
    int lat;
    send_req(1'b1, 8'h10, 32'hDEADBEEF, 4'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_en, mem_wen, wr_done} !== ((k == 0) ? 3'b110 : 3'b001)) begin
        errors++;
        $display("FAIL single_write_cycle%0d: got en/wen/done %b, expected %b",
                 k, {mem_en, mem_wen, wr_done}, (k == 0) ? 3'b110 : 3'b001);
      end
    end
    wait_idle();
    send_req(1'b0, 8'h10, 32'h0, 4'd0);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles, expected 3", lat);
    end
    checks++;
    if ({rsp_rdata, rsp_last} !== {32'hDEADBEEF, 1'b1}) begin
      errors++;
      $display("FAIL single_read: got %h last %b, expected deadbeef last 1", rsp_rdata, rsp_last);
    end
    wait_idle();
  endtask

  task automatic test_fill();
    send_req(1'b1, 8'hFE, 32'h5A5A5A5A, 4'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_wen !== (k < 4)) begin
        errors++;
        $display("FAIL fill_cycle%0d: got mem_wen %b, expected %b", k, mem_wen, (k < 4));
      end
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, 8'hFE + 8'(i), 32'h0, 4'd0);
      wait_idle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    for (int i = 0; i < 4; i++) begin
      send_req(1'b1, 8'hFE + 8'(i), 32'hC0DE0000 + 32'(i), 4'd0);
      wait_idle();
    end
    send_req(1'b0, 8'hFE, 32'h0, 4'd3);
    for (int b = 0; b < 4; b++) begin
      wait_rsp();
      checks++;
      if (rsp_last !== (b == 3)) begin
        errors++;
        $display("FAIL bp_last_beat%0d: got %b, expected %b", b, rsp_last, (b == 3));
      end
      if (b == 1) begin
        held = rsp_rdata;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          checks++;
          if ({rsp_valid, rsp_rdata} !== {1'b1, held}) begin
            errors++;
            $display("FAIL bp_stall%0d: got valid %b data %h, expected valid 1 data %h",
                     s, rsp_valid, rsp_rdata, held);
          end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
        if (b == 0) rsp_ready = 1'b0;
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    b2b_mon = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send_req(1'b1, 8'h80 + 8'(i * 2), 32'hA0000000 + 32'(i), 4'd1);
      else            send_req(1'b0, 8'h80 + 8'((i - 1) * 2), 32'h0, 4'd1);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_after_accept%0d: got %b, expected 0", i, req_ready);
      end
    end
    wait_idle();
    b2b_mon = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    send_req(1'b1, 8'h20, 32'h13579BDF, 4'd7);
    wait_idle();
    send_req(1'b0, 8'h20, 32'h0, 4'd7);
    wait_rsp();
    @(posedge clk); #1 rsp_ready = 1'b0;
    wait_rsp();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, rsp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL async_reset: got en/valid/ready %b, expected 001", {mem_en, rsp_valid, req_ready});
    end
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    send_req(1'b0, 8'h21, 32'h0, 4'd0);
    wait_rsp();
    checks++;
    if (rsp_rdata !== 32'h13579BDF) begin
      errors++;
      $display("FAIL read_after_reset: got %h, expected 13579bdf", rsp_rdata);
    end
    wait_idle();
  endtask

  task automatic test_stats();
    logic [15:0] exp_wr, exp_rd;
`ifdef MEM_REQUESTER_STATS_EN
    exp_wr = 16'd3; exp_rd = 16'd5;
`else
    exp_wr = 16'd0; exp_rd = 16'd0;
`endif
    do_reset();
    send_req(1'b1, 8'h40, 32'h0BADF00D, 4'd2);
    wait_idle();
    send_req(1'b0, 8'h40, 32'h0, 4'd4);
    wait_idle();
    checks++;
    if ({stat_wr_cnt, stat_rd_cnt} !== {exp_wr, exp_rd}) begin
      errors++;
      $display("FAIL stats: got wr %0d rd %0d, expected wr %0d rd %0d",
               stat_wr_cnt, stat_rd_cnt, exp_wr, exp_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_stats();
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got pending writes %0d reads %0d, expected 0", wq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
